cbus_arbiter: RTL and testbench

Shares one cache-bus (cbus) master port between N cache-side requesters: ICache, DCache, and later an uncached path. It picks one valid requester with round-robin priority and latches its request. It forwards that request downstream and routes the response back until the burst's last beat completes. It sits between the cache controllers and the AXI/cbus bridge in the CPU top level.

---
 rtl/cbus_arbiter_pkg.sv | 32 +++
 rtl/cbus_arbiter_if.sv | 31 +++
 rtl/cbus_arbiter_rr_pick.sv | 30 +++
 rtl/cbus_arbiter.sv | 103 ++++++++++
 tb/tb_cbus_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus payload types and zero constants for the cbus arbiter slice.
//   cbus_req_t  : request from a cache controller (valid, direction, size, addr, len, data, strobe)
//   cbus_resp_t : response beat from the bus bridge (ready, last, data)
package cbus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  // len encodes beats-1
  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strobe;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  localparam cbus_req_t  CBUS_REQ_ZERO  = '0;
  localparam cbus_resp_t CBUS_RESP_ZERO = '0;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of cache-side and bridge-side cbus signals around the arbiter.
//   ireqs  : requests from the caches          iresps : responses to the caches
//   oreq   : request to the bus bridge         oresp  : response from the bus bridge
// master is the arbiter's view (it masters the shared downstream port);
// slave is the view of the surrounding caches and bridge.
interface cbus_arbiter_if
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
);

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (
    input  ireqs,
    output iresps,
    output oreq,
    input  oresp
  );

  modport slave (
    output ireqs,
    input  iresps,
    input  oreq,
    output oresp
  );

endinterface

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index at or after ptr, wrapping.
//   valid : per-requester valid vector     ptr : highest-priority index
//   found : some requester is valid        idx : winning index
module cbus_arbiter_rr_pick #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned IDX_BIT    = 1
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_BIT-1:0]    ptr,
  output logic                  found,
  output logic [IDX_BIT-1:0]    idx
);

  logic [IDX_BIT-1:0] cand;

  // Scan NUM_INPUTS positions starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      cand = IDX_BIT'((32'(ptr) + k) % NUM_INPUTS);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus master port between NUM_INPUTS cache requesters.
//   clk, reset : clock and synchronous active-high reset
//   bus        : ireqs/iresps (cache side), oreq/oresp (bridge side)
// The winning request is latched and driven on oreq until the last response beat;
// responses are steered combinationally to the granted requester.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned IDX_BIT    = 1
) (
  input  logic          clk,
  input  logic          reset,
  cbus_arbiter_if.master bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [IDX_BIT-1:0] ptr;
  logic [IDX_BIT-1:0] sel;
  cbus_req_t          saved_req;

  logic [NUM_INPUTS-1:0] req_valid_c;
  logic                  pick_found_c;
  logic [IDX_BIT-1:0]    pick_idx_c;
  logic                  burst_done_c;
  logic [IDX_BIT-1:0]    ptr_next_c;

  // Gather valid bits for the selector
  always_comb begin
    req_valid_c = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      req_valid_c[i] = bus.ireqs[i].valid;
    end
  end

  cbus_arbiter_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_BIT    (IDX_BIT)
  ) u_rr_pick (
    .valid (req_valid_c),
    .ptr   (ptr),
    .found (pick_found_c),
    .idx   (pick_idx_c)
  );

  assign burst_done_c = (state_q == BUSY) && bus.oresp.ready && bus.oresp.last;
  // Winner drops to lowest priority
  assign ptr_next_c   = (sel == IDX_BIT'(NUM_INPUTS - 1)) ? '0 : sel + IDX_BIT'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found_c) state_d = BUSY;
      BUSY:    if (burst_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping; saved_req doubles as the registered oreq and is cleared when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      sel       <= '0;
      saved_req <= CBUS_REQ_ZERO;
    end else if (state_q == IDLE && pick_found_c) begin
      saved_req       <= bus.ireqs[pick_idx_c];
      saved_req.valid <= 1'b1;
      sel             <= pick_idx_c;
    end else if (burst_done_c) begin
      ptr       <= ptr_next_c;
      saved_req <= CBUS_REQ_ZERO;
    end
  end

  assign bus.oreq = saved_req;

  // Output logic: steer the bridge response to the granted requester only
  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      bus.iresps[i] = CBUS_RESP_ZERO;
      if (state_q == BUSY && sel == IDX_BIT'(i)) begin
        bus.iresps[i] = bus.oresp;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: expected grants are queued when requests are
// raised and checked when oreq becomes valid; each beat is checked as it is routed.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int unsigned NI = 2;
  localparam int unsigned IB = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_INPUTS(NI)) bus ();

  cbus_arbiter #(
    .NUM_INPUTS (NI),
    .IDX_BIT    (IB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int        port;
    cbus_req_t req;
  } grant_t;

  grant_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mkreq(input logic [31:0] addr, input logic [7:0] len, input logic wr);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd3;
    r.addr     = addr;
    r.len      = len;
    r.data     = {addr, ~addr};
    r.strobe   = '1;
    return r;
  endfunction

  // Raise a request and record the grant it should eventually produce
  task automatic request(input int port, input logic [31:0] addr, input logic [7:0] len, input logic wr);
    grant_t g;
    g.port = port;
    g.req  = mkreq(addr, len, wr);
    bus.ireqs[port] = g.req;
    sb.push_back(g);
  endtask

  task automatic check_all_resp_zero(input string tag);
    for (int j = 0; j < int'(NI); j++) begin
      check($sformatf("%s_iresp%0d", tag, j), 128'(bus.iresps[j]), 128'(CBUS_RESP_ZERO));
    end
  endtask

  // Wait for the next grant, play its burst, then check the idle bubble.
  task automatic do_burst(input int stall_at, input int stall_len, input logic drop, input int mut_at);
    grant_t     g;
    cbus_resp_t r;
    int         waited;
    int         nbeats;
    check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
    if (sb.size() == 0) return;
    g = sb.pop_front();
    waited = 0;
    while (bus.oreq.valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check($sformatf("grant_latency_p%0d", g.port), 128'(waited), 128'(1));
    if (bus.oreq.valid !== 1'b1) return;
    check($sformatf("grant_req_p%0d", g.port), 128'(bus.oreq), 128'(g.req));
    nbeats = int'(g.req.len) + 1;
    for (int b = 0; b < nbeats; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          r       = '0;
          r.data  = 64'hdead_0000_0000_0000 | 64'(s);
          bus.oresp = r;
          #1;
          check("stall_ready", 128'(bus.iresps[g.port].ready), 128'(0));
          check("stall_oreq", 128'(bus.oreq), 128'(g.req));
          tick();
        end
      end
      if (b == mut_at) begin
        bus.ireqs[g.port].addr = g.req.addr ^ 32'h0000_3000;
      end
      r.ready = 1'b1;
      r.last  = (b == nbeats - 1);
      r.data  = {g.req.addr, 32'(b)};
      bus.oresp = r;
      #1;
      check($sformatf("beat%0d_p%0d", b, g.port), 128'(bus.iresps[g.port]), 128'(r));
      for (int j = 0; j < int'(NI); j++) begin
        if (j != g.port) begin
          check($sformatf("beat%0d_other%0d", b, j), 128'(bus.iresps[j]), 128'(CBUS_RESP_ZERO));
        end
      end
      check($sformatf("hold_oreq_b%0d", b), 128'(bus.oreq), 128'(g.req));
      if (r.last && drop) bus.ireqs[g.port].valid = 1'b0;
      tick();
    end
    bus.oresp = CBUS_RESP_ZERO;
    #1;
    check("bubble_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    check_all_resp_zero("bubble");
  endtask

  initial begin
    reset     = 1'b1;
    bus.oresp = CBUS_RESP_ZERO;
    for (int i = 0; i < int'(NI); i++) bus.ireqs[i] = CBUS_REQ_ZERO;

    // Reset state
    tick();
    tick();
    check("reset_oreq", 128'(bus.oreq), 128'(CBUS_REQ_ZERO));
    check_all_resp_zero("reset");
    reset = 1'b0;
    tick();
    check("post_reset_oreq", 128'(bus.oreq), 128'(CBUS_REQ_ZERO));

    // Single request on port 1, 4 beats
    request(1, 32'h8000_0100, 8'd3, 1'b0);
    do_burst(-1, 0, 1'b1, -1);

    // Simultaneous requests: port 0 first, then port 1 after one bubble
    request(0, 32'h1000_0000, 8'd1, 1'b0);
    request(1, 32'h2000_0000, 8'd2, 1'b1);
    do_burst(-1, 0, 1'b1, -1);
    do_burst(-1, 0, 1'b1, -1);

    // Both always valid: grants must alternate, first grant shows ptr back at 0
    bus.ireqs[1] = mkreq(32'h2000_0040, 8'd3, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) request(0, 32'h1000_0040, 8'd3, 1'b1);
      else            request(1, 32'h2000_0040, 8'd3, 1'b0);
      do_burst(-1, 0, (k == 7), -1);
    end
    bus.ireqs[0].valid = 1'b0;

    // Request mutation mid-burst is ignored
    request(0, 32'h0000_1000, 8'd3, 1'b0);
    do_burst(-1, 0, 1'b1, 1);

    // Reset after beat 2 of 4 (ptr is 1 going in)
    bus.ireqs[0] = mkreq(32'h0000_3000, 8'd3, 1'b0);
    tick();
    check("rst_burst_grant", 128'(bus.oreq.valid), 128'(1));
    for (int b = 0; b < 2; b++) begin
      bus.oresp = '{ready: 1'b1, last: 1'b0, data: 64'(b)};
      tick();
    end
    bus.oresp = '{ready: 1'b1, last: 1'b0, data: 64'h2};
    reset = 1'b1;
    bus.ireqs[0].valid = 1'b0;
    tick();
    check("midrst_oreq", 128'(bus.oreq), 128'(CBUS_REQ_ZERO));
    check_all_resp_zero("midrst");
    reset     = 1'b0;
    bus.oresp = CBUS_RESP_ZERO;
    tick();
    check("after_rst_oreq", 128'(bus.oreq), 128'(CBUS_REQ_ZERO));
    // ptr must be 0 again: port 0 beats port 1
    request(0, 32'h0000_5000, 8'd0, 1'b0);
    request(1, 32'h0000_6000, 8'd1, 1'b1);
    do_burst(-1, 0, 1'b1, -1);
    do_burst(-1, 0, 1'b1, -1);

    // Stalled bridge: 5 idle cycles after the first beat
    request(1, 32'h4000_0040, 8'd3, 1'b0);
    do_burst(1, 5, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
